// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: program-counter generator for the front of the pipeline.
// Holds the architectural PC. The PC advances by INC on each accepted fetch,
// and trap and branch/jump redirects override that advance. The block drives
// a valid/ready request to instruction memory and supports halt and resume.
// Optional feature: define PC_ALIGN_CHECK_EN to turn on the redirect-target
// alignment check. A misaligned target then vectors to TRAP_VEC and pulses
// misalign_err.
module pc_fetch_gen #(
  parameter int              XLEN      = 32,
  parameter int              INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  input  logic             redirect_en,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_en,
  input  logic             halt,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   pc_nxt;
  logic              accept;
  logic              redir_bad;

  // fetch_valid decodes the state register directly. No input reaches it
  // combinationally.
  assign fetch_valid = (state == RUN);
  assign accept      = fetch_valid && fetch_ready;
  assign pc_plus_inc = fetch_pc + XLEN'(INC);

`ifdef PC_ALIGN_CHECK_EN
  // Low address bits that must be zero for a legal target:
  // [1:0] when INC=4, [0] when INC=2.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  // A trap in the same cycle takes priority, so it suppresses the check.
  assign redir_bad = redirect_en && !trap_en && (|(redirect_pc & ALIGN_MASK));

  // Registered one-cycle error pulse that accompanies the vector to TRAP_VEC.
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= redir_bad;
  end
`else
  assign redir_bad    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Next-state logic. A trap always forces RUN for one cycle, and halt is
  // evaluated again on the following edge.
  always_comb begin
    // NOTE: giving every always_comb output a default first guarantees that
    // no path leaves it unassigned, so no latch can be inferred.
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = (halt && !trap_en) ? HALT : RUN;
      RUN:     if (halt && !trap_en) state_nxt = HALT;
      HALT:    if (!halt || trap_en) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Next-PC selection. The priority order is trap, redirect, accept, hold.
  // A redirect abandons any pending request that was not accepted.
  always_comb begin
    pc_nxt = fetch_pc;
    if (trap_en || redir_bad) pc_nxt = TRAP_VEC;
    else if (redirect_en)     pc_nxt = redirect_pc;
    else if (accept)          pc_nxt = pc_plus_inc;
  end

  // State, PC and saturating accepted-fetch counter. Reset overrides all inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, and simulation matches the synthesised
    // flops.
    if (rst) begin
      state     <= BOOT;
      fetch_pc  <= RESET_VEC;
      fetch_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      if (accept && (fetch_cnt != {CNT_W{1'b1}}))
        fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed, scoreboard-checked bench for pc_fetch_gen.
// The bench drives two instances from the same inputs. One uses the default
// parameters. The other uses CNT_W=2, so counter saturation can be observed.
module tb_pc_fetch_gen;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        trap_en;
  logic        halt;

  logic        fetch_valid, fetch_valid_s;
  logic [31:0] fetch_pc, fetch_pc_s;
  logic [31:0] pc_plus_inc, pc_plus_inc_s;
  logic [15:0] fetch_cnt;
  logic [1:0]  fetch_cnt_s;
  logic        misalign_err, misalign_err_s;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  pc_fetch_gen dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .pc_plus_inc(pc_plus_inc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .trap_en(trap_en), .halt(halt),
    .fetch_cnt(fetch_cnt), .misalign_err(misalign_err)
  );

  pc_fetch_gen #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid_s), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc_s), .pc_plus_inc(pc_plus_inc_s),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .trap_en(trap_en), .halt(halt),
    .fetch_cnt(fetch_cnt_s), .misalign_err(misalign_err_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  // Sample 1 time unit after the edge, then pop and compare.
  task automatic step(input string tag, input logic r, input logic rdy, input logic h,
                      input logic redir, input logic [31:0] rpc, input logic trap,
                      input logic ev, input logic [31:0] epc, input logic [15:0] ecnt,
                      input logic eerr);
    exp_t e;
    logic [1:0] ecnt_s;
    rst = r; fetch_ready = rdy; halt = h;
    redirect_en = redir; redirect_pc = rpc; trap_en = trap;
    sb.push_back('{tag, ev, epc, ecnt, eerr});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    ecnt_s = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
    check({e.tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, e.valid});
    check({e.tag, ".pc"},    fetch_pc, e.pc);
    check({e.tag, ".ppi"},   pc_plus_inc, e.pc + 32'd4);
    check({e.tag, ".cnt"},   {16'd0, fetch_cnt}, {16'd0, e.cnt});
    check({e.tag, ".cnt2"},  {30'd0, fetch_cnt_s}, {30'd0, ecnt_s});
    check({e.tag, ".err"},   {31'd0, misalign_err}, {31'd0, e.err});
  endtask

  initial begin
    //    tag           rst rdy hlt red rpc           trp  v   pc             cnt  err
    step("rst_a",       1,  1,  0,  0,  32'h0,        0,   0,  32'h0,         0,   0);
    step("rst_b",       1,  1,  0,  0,  32'h0,        0,   0,  32'h0,         0,   0);
    step("boot",        0,  1,  0,  0,  32'h0,        0,   1,  32'h0,         0,   0);
    step("acc0",        0,  1,  0,  0,  32'h0,        0,   1,  32'h4,         1,   0);
    step("acc4",        0,  1,  0,  0,  32'h0,        0,   1,  32'h8,         2,   0);
    step("stall1",      0,  0,  0,  0,  32'h0,        0,   1,  32'h8,         2,   0);
    step("stall2",      0,  0,  0,  0,  32'h0,        0,   1,  32'h8,         2,   0);
    step("stall3",      0,  0,  0,  0,  32'h0,        0,   1,  32'h8,         2,   0);
    step("acc8",        0,  1,  0,  0,  32'h0,        0,   1,  32'hC,         3,   0);
    step("trap_redir",  0,  0,  0,  1,  32'h200,      1,   1,  32'h100,       3,   0);
    step("hold",        0,  0,  0,  0,  32'h0,        0,   1,  32'h100,       3,   0);
    step("redir_acc",   0,  1,  0,  1,  32'h200,      0,   1,  32'h200,       4,   0);
    step("redir_top",   0,  0,  0,  1,  32'hFFFF_FFFC,0,   1,  32'hFFFF_FFFC, 4,   0);
    step("wrap",        0,  1,  0,  0,  32'h0,        0,   1,  32'h0,         5,   0);
    step("halt_pend",   0,  0,  1,  0,  32'h0,        0,   0,  32'h0,         5,   0);
    step("halt_rdy",    0,  1,  1,  0,  32'h0,        0,   0,  32'h0,         5,   0);
    step("halt_redir",  0,  0,  1,  1,  32'h40,       0,   0,  32'h40,        5,   0);
    step("halt_trap",   0,  0,  1,  0,  32'h0,        1,   1,  32'h100,       5,   0);
    step("halt_again",  0,  0,  1,  0,  32'h0,        0,   0,  32'h100,       5,   0);
    step("resume",      0,  1,  0,  0,  32'h0,        0,   1,  32'h100,       5,   0);
    step("acc100",      0,  1,  0,  0,  32'h0,        0,   1,  32'h104,       6,   0);
    step("misalign",    0,  0,  0,  1,  32'h202,      0,   1,
         ALIGN_CHK ? 32'h100 : 32'h202, 6, ALIGN_CHK);
    step("err_clr",     0,  0,  0,  0,  32'h0,        0,   1,
         ALIGN_CHK ? 32'h100 : 32'h202, 6, 0);
    step("trap_mis",    0,  0,  0,  1,  32'h202,      1,   1,  32'h100,       6,   0);
    step("rst_mid",     1,  0,  0,  0,  32'h0,        0,   0,  32'h0,         0,   0);
    step("boot2",       0,  1,  0,  0,  32'h0,        0,   1,  32'h0,         0,   0);
    step("trap_acc",    0,  1,  0,  0,  32'h0,        1,   1,  32'h100,       1,   0);
    step("acc_after",   0,  1,  0,  0,  32'h0,        0,   1,  32'h104,       2,   0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
